tour_solver_param: RTL and testbench
====================================

Name: tour_solver_param

Overview:
Parametrised successor to the 5x5 knight's-tour solver. Solves an open knight's tour on a BOARD_DIM x BOARD_DIM board by depth-first search with backtracking, starting from a given square. Adds the following over the previous generation:
- size generality
- a fail indication when no tour exists
- abort
- busy/status
- start-square validation
- 1-bit visited map

Sits between the command processor (which issues go and the start square) and the move replayer (which reads moves by index).

Parameters:
BOARD_DIM, 5, board side length; legal range 3..8.
XY_W, 3, coordinate width; fixed at 3, which covers up to 8.
NUM_MOVES, BOARD_DIM*BOARD_DIM-1, moves in a complete tour (derived, not overridable).
IDX_W, $clog2(NUM_MOVES), width of move index (derived).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
go  in  1  start solve; sampled only in IDLE
abort  in  1  cancel an in-progress solve
x_start  in  XY_W  start column
y_start  in  XY_W  start row
indx  in  IDX_W  index of solution move to read
move  out  8  one-hot move at indx
done  out  1  1-cycle pulse: tour found
fail  out  1  1-cycle pulse: no tour, or illegal start square
busy  out  1  high in every state except IDLE
move_num  out  IDX_W+1  current search depth (debug/status)

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high (rst).
- Reset state: IDLE. done=0, fail=0, busy=0, move_num=0. Every last_move entry is 0, so move=0.
- Move encoding (one-hot, bit: dx,dy):
  - b0: +1,+2
  - b1: -1,+2
  - b2: -2,+1
  - b3: -2,-1
  - b4: -1,-2
  - b5: +1,-2
  - b6: +2,-1
  - b7: +2,+1
- Try order: candidate moves are tried in order b0 through b7.
- Coordinate arithmetic: signed, XY_W+1 bits. A target is in bounds iff 0 <= x,y <= BOARD_DIM-1. Negative results must never alias to legal squares.
- Visited map: BOARD_DIM*BOARD_DIM 1-bit flags, cleared on go.
- Per-depth arrays, NUM_MOVES entries each:
  - poss[d]: in-bounds mask at depth d
  - last_move[d]: one-hot move taken at depth d
- IDLE:
  - go=1 with x_start or y_start >= BOARD_DIM: pulse fail the next cycle and stay in IDLE.
  - go=1 with a legal start square: go to INIT.
  - go while busy is ignored.
- INIT (1 cycle):
  - clear the visited map, then mark the start square
  - set xx,yy to the start square
  - move_num=0
  - go to POSS
- POSS (1 cycle): poss[move_num] = bounds mask of (xx,yy); try=b0; go to TRY.
- TRY (one candidate per cycle):
  - Candidate valid (poss bit set and target unvisited):
    - last_move[move_num]=try
    - mark target visited; xx,yy=target; move_num++
    - if move_num was NUM_MOVES-1, go to DONE; else go to POSS
  - Candidate invalid and try != b7: shift try left by 1.
  - Candidate invalid and try == b7: go to BACK.
- BACK (1 cycle):
  - If move_num==0: go to FAIL (search exhausted).
  - Otherwise:
    - clear visited at xx,yy
    - undo last_move[move_num-1] on xx,yy
    - move_num--
  - After the undo:
    - if the undone move was b7, stay in BACK
    - else set try = undone move << 1 and go to TRY
- DONE: pulse done for 1 cycle, go to IDLE. last_move is retained until the next go.
- FAIL: pulse fail for 1 cycle, go to IDLE.
- abort:
  - In any non-IDLE state, abort forces IDLE on the next edge with no done/fail pulse. Abort has priority over all transitions.
  - Array contents are then undefined for readout.
- Readout: move = last_move[indx], purely combinational from indx. Returns 0 when indx >= NUM_MOVES.
- done and fail are never high in the same cycle.
- rst mid-solve returns to IDLE immediately; no pulse follows.

Decomposition:
- Package tour_pkg holds:
  - move one-hot constants MV_0..MV_7
  - functions off_x/off_y, returning signed 4-bit offsets; default 0 for non-one-hot input
  - state_t enum: IDLE, INIT, POSS, TRY, BACK, DONE, FAIL
- Sub-module tour_move_gen, combinational, parametrised by BOARD_DIM:
  - inputs: xx, yy, try
  - outputs: in-bounds 8-bit mask, target x/y, target_in_bounds
  - reused for both the POSS mask and the TRY target computation
- Top holds the FSM, visited map, depth arrays and readout.

Test Plan:
- BOARD_DIM=5, go with start (0,0):
  - done pulses exactly once; fail never.
  - move[0]=8'h01.
  - Replaying moves 0..23 from (0,0) visits all 25 squares once with every step in bounds.
  - busy low after done.
- BOARD_DIM=5, start (2,2): done. Bench replay checker confirms 24 distinct legal moves; move[24..31] read 0.
- BOARD_DIM=3, start (0,0): fail pulses once; done never; busy returns low.
- BOARD_DIM=6, start (0,0): done. Replay covers all 36 squares; the maximum of the move_num output equals 35.
- BOARD_DIM=5, go with x_start=5: fail pulses on the cycle after go; busy stays 0; no state leaves IDLE.
- BOARD_DIM=5:
  - abort asserted 50 cycles after go: busy=0 next cycle, no done/fail.
  - Re-go from (0,0) then completes with done.
  - Repeat with rst in place of abort: same result.
  - Also pulse go while busy: ignored.

Source files
------------

// File: rtl/tour_pkg.sv
// tour_pkg: move encodings, knight offsets and solver states
// shared by the knight's-tour solver, its move generator and interface.
package tour_pkg;

    localparam int XY_W = 3;

    localparam logic [7:0] MV_0 = 8'h01;
    localparam logic [7:0] MV_1 = 8'h02;
    localparam logic [7:0] MV_2 = 8'h04;
    localparam logic [7:0] MV_3 = 8'h08;
    localparam logic [7:0] MV_4 = 8'h10;
    localparam logic [7:0] MV_5 = 8'h20;
    localparam logic [7:0] MV_6 = 8'h40;
    localparam logic [7:0] MV_7 = 8'h80;

    typedef enum logic [2:0] {
        IDLE, INIT, POSS, TRY, BACK, DONE, FAIL
    } state_t;

    function automatic logic signed [XY_W:0] off_x(
        input logic [7:0] mv
    );
        case (mv)
            MV_0:    off_x = 4'sd1;
            MV_1:    off_x = -4'sd1;
            MV_2:    off_x = -4'sd2;
            MV_3:    off_x = -4'sd2;
            MV_4:    off_x = -4'sd1;
            MV_5:    off_x = 4'sd1;
            MV_6:    off_x = 4'sd2;
            MV_7:    off_x = 4'sd2;
            default: off_x = 4'sd0;
        endcase
    endfunction

    function automatic logic signed [XY_W:0] off_y(
        input logic [7:0] mv
    );
        case (mv)
            MV_0:    off_y = 4'sd2;
            MV_1:    off_y = 4'sd2;
            MV_2:    off_y = 4'sd1;
            MV_3:    off_y = -4'sd1;
            MV_4:    off_y = -4'sd2;
            MV_5:    off_y = -4'sd2;
            MV_6:    off_y = -4'sd1;
            MV_7:    off_y = 4'sd1;
            default: off_y = 4'sd0;
        endcase
    endfunction

endpackage

// File: rtl/tour_solver_param_if.sv
// tour_solver_param_if: command/readout bundle of the solver.
// master = command processor / replayer side, slave = solver.
interface tour_solver_param_if #(
    parameter int BOARD_DIM = 5
);
    import tour_pkg::*;

    localparam int NUM_MOVES = BOARD_DIM * BOARD_DIM - 1;
    localparam int IDX_W     = $clog2(NUM_MOVES);

    logic            go;
    logic            abort;
    logic [XY_W-1:0] x_start;
    logic [XY_W-1:0] y_start;
    logic [IDX_W-1:0] indx;
    logic [7:0]      move;
    logic            done;
    logic            fail;
    logic            busy;
    logic [IDX_W:0]  move_num;

    modport master (
        output go, abort, x_start, y_start, indx,
        input  move, done, fail, busy, move_num
    );

    modport slave (
        input  go, abort, x_start, y_start, indx,
        output move, done, fail, busy, move_num
    );

endinterface

// File: rtl/tour_move_gen.sv
// tour_move_gen: knight-move geometry from (xx,yy); gives the 8-bit
// in-bounds mask and the target square of the one-hot move try_mv.
module tour_move_gen
    import tour_pkg::*;
#(
    parameter int BOARD_DIM = 5
) (
    input  logic [XY_W-1:0] xx,
    input  logic [XY_W-1:0] yy,
    input  logic [7:0]      try_mv,
    output logic [7:0]      mask,
    output logic [XY_W-1:0] tx,
    output logic [XY_W-1:0] ty,
    output logic            t_in
);

    localparam logic [XY_W-1:0] MAXC = XY_W'(BOARD_DIM - 1);

    // Sums wrap in XY_W+1 bits; any wrap lands negative, never legal.
    function automatic logic in_rng(
        input logic signed [XY_W:0] c
    );
        in_rng = !c[XY_W] && (c[XY_W-1:0] <= MAXC);
    endfunction

    logic signed [XY_W:0] sx, sy, nx, ny;
    logic [7:0] mv_k;

    assign sx = $signed({1'b0, xx});
    assign sy = $signed({1'b0, yy});

    always_comb begin
        mask = '0;
        mv_k = '0;
        for (int k = 0; k < 8; k++) begin
            mv_k    = 8'h01 << k;
            mask[k] = in_rng(sx + off_x(mv_k))
                   && in_rng(sy + off_y(mv_k));
        end
    end

    assign nx   = sx + off_x(try_mv);
    assign ny   = sy + off_y(try_mv);
    assign tx   = nx[XY_W-1:0];
    assign ty   = ny[XY_W-1:0];
    assign t_in = in_rng(nx) && in_rng(ny);

endmodule

// File: rtl/tour_solver_param.sv
// tour_solver_param: DFS knight's-tour solver with backtracking.
// Ports: clk, rst (async high), bus (go/abort/start in, move/status out).
module tour_solver_param
    import tour_pkg::*;
#(
    parameter int BOARD_DIM = 5
) (
    input logic                clk,
    input logic                rst,
    tour_solver_param_if.slave bus
);

    localparam int NUM_MOVES = BOARD_DIM * BOARD_DIM - 1;
    localparam int IDX_W     = $clog2(NUM_MOVES);
    localparam int NSQ       = BOARD_DIM * BOARD_DIM;
    localparam int SQ_W      = $clog2(NSQ);

    localparam logic [IDX_W:0]  LAST  = (IDX_W+1)'(NUM_MOVES - 1);
    localparam logic [IDX_W:0]  NM    = (IDX_W+1)'(NUM_MOVES);
    localparam logic [IDX_W:0]  ONE_M = (IDX_W+1)'(1);
    localparam logic [XY_W:0]   DIM4  = (XY_W+1)'(BOARD_DIM);
    localparam logic [NSQ-1:0]  VIS1  = NSQ'(1);

    function automatic logic [SQ_W-1:0] sq(
        input logic [XY_W-1:0] x,
        input logic [XY_W-1:0] y
    );
        sq = SQ_W'(int'(y) * BOARD_DIM + int'(x));
    endfunction

    state_t          st;
    logic [NSQ-1:0]  vis;
    logic [7:0]      poss    [NUM_MOVES];
    logic [7:0]      last_mv [NUM_MOVES];
    logic [XY_W-1:0] xx, yy;
    logic [7:0]      try_q;
    logic [IDX_W:0]  mnum;
    logic            done_q, fail_q;

    logic [IDX_W-1:0] mi, mb;
    logic [7:0]       mask, lm;
    logic [XY_W-1:0]  tx, ty;
    logic             t_in, cand_ok, bad_start;
    logic signed [XY_W:0] ux, uy;

    tour_move_gen #(.BOARD_DIM(BOARD_DIM)) u_gen (
        .xx     (xx),
        .yy     (yy),
        .try_mv (try_q),
        .mask   (mask),
        .tx     (tx),
        .ty     (ty),
        .t_in   (t_in)
    );

    assign mi = mnum[IDX_W-1:0];
    assign mb = mi - IDX_W'(1);
    assign lm = last_mv[mb];

    // Step back along the move taken into the current square.
    assign ux = $signed({1'b0, xx}) - off_x(lm);
    assign uy = $signed({1'b0, yy}) - off_y(lm);

    assign cand_ok = t_in && |(try_q & poss[mi])
                  && !vis[sq(tx, ty)];

    assign bad_start = ({1'b0, bus.x_start} >= DIM4)
                    || ({1'b0, bus.y_start} >= DIM4);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st     <= IDLE;
            vis    <= '0;
            xx     <= '0;
            yy     <= '0;
            try_q  <= MV_0;
            mnum   <= '0;
            done_q <= 1'b0;
            fail_q <= 1'b0;
            for (int i = 0; i < NUM_MOVES; i++) begin
                poss[i]    <= '0;
                last_mv[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            fail_q <= 1'b0;
            if (bus.abort && st != IDLE) begin
                st <= IDLE;
            end else begin
                unique case (st)
                    IDLE: if (bus.go) begin
                        if (bad_start) begin
                            fail_q <= 1'b1;
                        end else begin
                            xx <= bus.x_start;
                            yy <= bus.y_start;
                            st <= INIT;
                        end
                    end
                    INIT: begin
                        vis  <= VIS1 << sq(xx, yy);
                        mnum <= '0;
                        st   <= POSS;
                    end
                    POSS: begin
                        poss[mi] <= mask;
                        try_q    <= MV_0;
                        st       <= TRY;
                    end
                    TRY: begin
                        if (cand_ok) begin
                            last_mv[mi]      <= try_q;
                            vis[sq(tx, ty)]  <= 1'b1;
                            xx               <= tx;
                            yy               <= ty;
                            mnum             <= mnum + ONE_M;
                            if (mnum == LAST) begin
                                done_q <= 1'b1;
                                st     <= DONE;
                            end else begin
                                st <= POSS;
                            end
                        end else if (try_q[7]) begin
                            st <= BACK;
                        end else begin
                            try_q <= try_q << 1;
                        end
                    end
                    BACK: begin
                        if (mnum == '0) begin
                            fail_q <= 1'b1;
                            st     <= FAIL;
                        end else begin
                            vis[sq(xx, yy)] <= 1'b0;
                            xx   <= ux[XY_W-1:0];
                            yy   <= uy[XY_W-1:0];
                            mnum <= mnum - ONE_M;
                            // Undoing b7 exhausts that depth too.
                            if (!lm[7]) begin
                                try_q <= lm << 1;
                                st    <= TRY;
                            end
                        end
                    end
                    DONE:    st <= IDLE;
                    FAIL:    st <= IDLE;
                    default: st <= IDLE;
                endcase
            end
        end
    end

    assign bus.done     = done_q;
    assign bus.fail     = fail_q;
    assign bus.busy     = (st != IDLE);
    assign bus.move_num = mnum;
    assign bus.move     = ({1'b0, bus.indx} < NM)
                        ? last_mv[bus.indx] : 8'h00;

endmodule

// File: tb/tb_tour_solver_param.sv
// tb_tour_solver_param: random-start and directed solves on 3x3,
// 5x5 and 6x6 boards checked against a DFS model and a replay check.
module tb_tour_solver_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst5, rst3, rst6;

    tour_solver_param_if #(.BOARD_DIM(5)) if5 ();
    tour_solver_param_if #(.BOARD_DIM(3)) if3 ();
    tour_solver_param_if #(.BOARD_DIM(6)) if6 ();

    tour_solver_param #(.BOARD_DIM(5)) dut5 (
        .clk(clk), .rst(rst5), .bus(if5.slave)
    );
    tour_solver_param #(.BOARD_DIM(3)) dut3 (
        .clk(clk), .rst(rst3), .bus(if3.slave)
    );
    tour_solver_param #(.BOARD_DIM(6)) dut6 (
        .clk(clk), .rst(rst6), .bus(if6.slave)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input longint act,
                       input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d",
                     name, act, exp);
        end
    endtask

    int DX[8] = '{1, -1, -2, -2, -1, 1, 2, 2};
    int DY[8] = '{2, 2, 1, -1, -2, -2, -1, 1};

    int         m_mv[64];
    bit         m_found;
    int         m_tries;
    logic [7:0] rd_mv[64];

    // Plain DFS over move indices 0..7 in try order.
    task automatic model_solve(input int n, input int sx,
                               input int sy);
        bit vis[64];
        int x, y, d, k, nx, ny;
        for (int i = 0; i < 64; i++) vis[i] = 0;
        x = sx; y = sy; d = 0; k = 0;
        vis[y*n+x] = 1;
        m_found = 0; m_tries = 0;
        while (1) begin
            if (d == n*n-1) begin
                m_found = 1;
                break;
            end
            if (k == 8) begin
                if (d == 0) break;
                d--;
                vis[y*n+x] = 0;
                x -= DX[m_mv[d]];
                y -= DY[m_mv[d]];
                k = m_mv[d] + 1;
            end else begin
                m_tries++;
                nx = x + DX[k];
                ny = y + DY[k];
                if (nx >= 0 && nx < n && ny >= 0 && ny < n
                    && !vis[ny*n+nx]) begin
                    m_mv[d] = k;
                    vis[ny*n+nx] = 1;
                    x = nx; y = ny; d++; k = 0;
                end else begin
                    k++;
                end
            end
        end
    endtask

    // Independent tour check on the one-hot moves read back.
    function automatic bit replay_ok(input int n, input int sx,
                                     input int sy);
        bit vis[64];
        int x, y, k, cnt;
        for (int i = 0; i < 64; i++) vis[i] = 0;
        x = sx; y = sy;
        vis[y*n+x] = 1;
        cnt = 1;
        for (int i = 0; i < n*n-1; i++) begin
            if (!$onehot(rd_mv[i])) return 0;
            k = 0;
            for (int j = 0; j < 8; j++)
                if (rd_mv[i][j]) k = j;
            x += DX[k];
            y += DY[k];
            if (x < 0 || x >= n || y < 0 || y >= n) return 0;
            if (vis[y*n+x]) return 0;
            vis[y*n+x] = 1;
            cnt++;
        end
        return cnt == n*n;
    endfunction

    int d5, f5, d3, f3, d6, f6, max6;

    always @(negedge clk) begin
        if (if5.done || if5.fail)
            chk("excl5", if5.done & if5.fail, 0);
        if (if3.done || if3.fail)
            chk("excl3", if3.done & if3.fail, 0);
        if (if6.done || if6.fail)
            chk("excl6", if6.done & if6.fail, 0);
        if (if5.done) d5++;
        if (if5.fail) f5++;
        if (if3.done) d3++;
        if (if3.fail) f3++;
        if (if6.done) d6++;
        if (if6.fail) f6++;
        if (int'(if6.move_num) > max6) max6 = int'(if6.move_num);
    end

    // Start a 5x5 solve; mode 1 adds a go while busy, mode 2 an
    // abort and mode 3 a reset at cycle 50 (no pulse expected).
    task automatic solve5(input string tag, input int sx,
                          input int sy, input int mode);
        int cyc, budget;
        bit got;
        model_solve(5, sx, sy);
        budget = 4 * m_tries + 200;
        @(negedge clk); #1;
        d5 = 0; f5 = 0;
        if5.x_start = 3'(sx);
        if5.y_start = 3'(sy);
        if5.go = 1'b1;
        @(negedge clk); #1;
        if5.go = 1'b0;
        cyc = 0;
        got = 0;
        while (!got && cyc < budget) begin
            @(negedge clk);
            cyc++;
            got = if5.done || if5.fail;
            if (mode == 1 && cyc == 10) begin
                if5.x_start = 3'd2; if5.y_start = 3'd2;
                if5.go = 1'b1;
            end
            if (mode == 1 && cyc == 11) begin
                if5.go = 1'b0;
                if5.x_start = 3'(sx); if5.y_start = 3'(sy);
            end
            if (mode >= 2 && cyc == 50) begin
                if (mode == 2) if5.abort = 1'b1;
                else rst5 = 1'b1;
                @(negedge clk);
                chk({tag, "_busy_cut"}, if5.busy, 0);
                if5.abort = 1'b0;
                rst5 = 1'b0;
                repeat (3) @(negedge clk);
                #1;
                chk({tag, "_no_done"}, d5, 0);
                chk({tag, "_no_fail"}, f5, 0);
                chk({tag, "_busy_idle"}, if5.busy, 0);
                return;
            end
        end
        chk({tag, "_in_time"}, cyc < budget, 1);
        @(negedge clk); #1;
        chk({tag, "_done_cnt"}, d5, m_found);
        chk({tag, "_fail_cnt"}, f5, !m_found);
        chk({tag, "_busy_after"}, if5.busy, 0);
        for (int i = 0; i < 32; i++) begin
            logic [7:0] e;
            if5.indx = 5'(i);
            #1;
            rd_mv[i] = if5.move;
            e = (i < 24) ? (8'h01 << m_mv[i]) : 8'h00;
            chk($sformatf("%s_move%0d", tag, i), rd_mv[i], e);
        end
        chk({tag, "_replay"}, replay_ok(5, sx, sy), 1);
    endtask

    initial begin
        int cyc, rx, ry;
        rst5 = 1'b1; rst3 = 1'b1; rst6 = 1'b1;
        if5.go = 0; if5.abort = 0; if5.x_start = 0;
        if5.y_start = 0; if5.indx = 0;
        if3.go = 0; if3.abort = 0; if3.x_start = 0;
        if3.y_start = 0; if3.indx = 0;
        if6.go = 0; if6.abort = 0; if6.x_start = 0;
        if6.y_start = 0; if6.indx = 0;

        model_solve(3, 0, 0);
        chk("model3_found", m_found, 0);
        model_solve(5, 0, 0);
        chk("model5_found", m_found, 1);
        chk("model5_mv0", m_mv[0], 0);

        repeat (2) @(negedge clk);
        rst5 = 1'b0; rst3 = 1'b0; rst6 = 1'b0;
        @(negedge clk);
        chk("rst_busy", if5.busy, 0);
        chk("rst_done", if5.done, 0);
        chk("rst_fail", if5.fail, 0);
        chk("rst_move_num", if5.move_num, 0);
        if5.indx = 5'd3;
        #1;
        chk("rst_move", if5.move, 0);

        solve5("s00", 0, 0, 0);
        chk("s00_move0_lit", rd_mv[0], 8'h01);
        solve5("s22", 2, 2, 0);

        // Random extra start square.
        rx = $urandom_range(4, 0);
        ry = $urandom_range(4, 0);
        solve5($sformatf("r%0d%0d", rx, ry), rx, ry, 0);

        // Illegal start squares.
        for (int t = 0; t < 2; t++) begin
            @(negedge clk); #1;
            if5.x_start = (t == 0) ? 3'd5 : 3'd1;
            if5.y_start = (t == 0) ? 3'd0 : 3'(5 + t);
            if5.go = 1'b1;
            @(negedge clk);
            chk("bad_fail", if5.fail, 1);
            chk("bad_busy", if5.busy, 0);
            #1;
            if5.go = 1'b0;
            @(negedge clk);
            chk("bad_fail_off", if5.fail, 0);
            chk("bad_busy_off", if5.busy, 0);
            chk("bad_done", if5.done, 0);
        end

        solve5("abort", 0, 0, 2);
        solve5("rego", 0, 0, 1);
        solve5("rstcut", 0, 0, 3);
        if5.indx = 5'd0;
        #1;
        chk("rstcut_move0", if5.move, 0);
        solve5("rego2", 0, 0, 0);

        // 3x3 has no tour.
        @(negedge clk); #1;
        d3 = 0; f3 = 0;
        if3.go = 1'b1;
        @(negedge clk); #1;
        if3.go = 1'b0;
        cyc = 0;
        while (!(if3.done || if3.fail) && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        chk("b3_in_time", cyc < 5000, 1);
        @(negedge clk); #1;
        chk("b3_fail_cnt", f3, 1);
        chk("b3_done_cnt", d3, 0);
        chk("b3_busy", if3.busy, 0);

        model_solve(6, 0, 0);
        if (m_tries <= 20000) begin
            @(negedge clk); #1;
            d6 = 0; f6 = 0; max6 = 0;
            if6.go = 1'b1;
            @(negedge clk); #1;
            if6.go = 1'b0;
            cyc = 0;
            while (!(if6.done || if6.fail)
                   && cyc < 4 * m_tries + 200) begin
                @(negedge clk);
                cyc++;
            end
            chk("b6_in_time", cyc < 4 * m_tries + 200, 1);
            @(negedge clk); #1;
            chk("b6_done_cnt", d6, 1);
            chk("b6_fail_cnt", f6, 0);
            chk("b6_max_move_num", max6, 35);
            for (int i = 0; i < 35; i++) begin
                if6.indx = 6'(i);
                #1;
                rd_mv[i] = if6.move;
                chk($sformatf("b6_move%0d", i), rd_mv[i],
                    8'h01 << m_mv[i]);
            end
            chk("b6_replay", replay_ok(6, 0, 0), 1);
        end else begin
            $display("note: 6x6 search of %0d tries not run",
                     m_tries);
        end

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
